// File: rtl/spi_pkg.sv
// spi_pkg: SUMP opcodes, long-command flag position and FSM state encoding shared by spi_cmd_master
package spi_pkg;
    localparam logic [7:0] OP_RESET       = 8'h00;
    localparam logic [7:0] OP_RUN         = 8'h01;
    localparam logic [7:0] OP_QUERY_ID    = 8'h02;
    localparam logic [7:0] OP_QUERY_META  = 8'h04;
    localparam logic [7:0] OP_QUERY_INPUT = 8'h06;
    localparam int LONG_BIT = 7;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_TX,
        S_RX,
        S_RWAIT,
        S_TRAIL,
        S_GAP
    } state_t;
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: CLK_DIV half-period tick source; phase is the SCLK level, hold parks it low and restarts the count
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick,
    output logic phase
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_END = CW'(CLK_DIV - 1);
    logic [CW-1:0] cnt;
    assign tick = !hold && cnt == CNT_END;
    always_ff @(posedge clk) begin
        if (rst || hold) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            phase <= phase ^ tick;
        end
    end
endmodule

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI mode-0 master sending 1/5-byte SUMP commands and streaming back response bytes.
// SPI_CMD_MASTER_READBACK_EN enables the MISO read-back path and the rsp_* stream.
module spi_cmd_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd_code,
    input  logic [31:0] cmd_data,
    input  logic [7:0]  cmd_rdlen,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  rsp_tdata,
    output logic        rsp_tvalid,
    output logic        rsp_tlast,
    input  logic        rsp_tready,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam logic [15:0] HALF_END = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_END  = 16'(CS_GAP - 1);
    state_t state;
    logic [39:0] tx_sh;
    logic [15:0] wait_cnt;
    logic [2:0] bit_cnt;
    logic [2:0] tx_left;
    logic hold;
    logic tick;
    logic phase;
    logic rise;
    logic fall;
    assign hold      = state != S_TX && state != S_RX;
    assign rise      = tick && !phase;
    assign fall      = tick && phase;
    assign cmd_ready = state == S_IDLE && !rst;
    assign busy      = state != S_IDLE;
    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .hold (hold),
        .tick (tick),
        .phase(phase)
    );
`ifdef SPI_CMD_MASTER_READBACK_EN
    logic [6:0] rx_sh;
    logic [7:0] rx_left;
`else
    logic unused_ok;
    assign unused_ok  = ^{cmd_rdlen, spi_miso, rsp_tready};
    assign rsp_tdata  = '0;
    assign rsp_tvalid = 1'b0;
    assign rsp_tlast  = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            tx_sh    <= '0;
            wait_cnt <= '0;
            bit_cnt  <= '0;
            tx_left  <= '0;
`ifdef SPI_CMD_MASTER_READBACK_EN
            rx_sh      <= '0;
            rx_left    <= '0;
            rsp_tdata  <= '0;
            rsp_tvalid <= 1'b0;
            rsp_tlast  <= 1'b0;
`endif
        end else begin
`ifdef SPI_CMD_MASTER_READBACK_EN
            if (rsp_tvalid && rsp_tready) rsp_tvalid <= 1'b0;
`endif
            case (state)
                S_IDLE: if (cmd_valid) begin
                    state    <= S_LEAD;
                    spi_cs_n <= 1'b0;
                    wait_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_left  <= cmd_code[LONG_BIT] ? 3'd4 : 3'd0;
                    tx_sh    <= {cmd_code, cmd_code[LONG_BIT] ?
                                 {cmd_data[7:0], cmd_data[15:8], cmd_data[23:16], cmd_data[31:24]} : 32'h0};
`ifdef SPI_CMD_MASTER_READBACK_EN
                    rx_left  <= cmd_rdlen;
`endif
                end
                S_LEAD: if (wait_cnt == HALF_END) begin
                    state    <= S_TX;
                    wait_cnt <= '0;
                    spi_mosi <= tx_sh[39];
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                S_TX: begin
                    if (rise) spi_sclk <= 1'b1;
                    if (fall) begin
                        spi_sclk <= 1'b0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        tx_sh    <= {tx_sh[38:0], 1'b0};
                        spi_mosi <= tx_sh[38];
                        if (bit_cnt == 3'd7 && tx_left != 3'd0) tx_left <= tx_left - 3'd1;
                        if (bit_cnt == 3'd7 && tx_left == 3'd0) begin
                            spi_mosi <= 1'b0;
`ifdef SPI_CMD_MASTER_READBACK_EN
                            state    <= rx_left != 8'd0 ? S_RX : S_TRAIL;
`else
                            state    <= S_TRAIL;
`endif
                        end
                    end
                end
`ifdef SPI_CMD_MASTER_READBACK_EN
                S_RX: begin
                    if (rise) begin
                        spi_sclk <= 1'b1;
                        rx_sh    <= {rx_sh[5:0], spi_miso};
                        if (bit_cnt == 3'd7) begin
                            rsp_tdata  <= {rx_sh, spi_miso};
                            rsp_tvalid <= 1'b1;
                            rsp_tlast  <= rx_left == 8'd1;
                            rx_left    <= rx_left - 8'd1;
                        end
                    end
                    if (fall) begin
                        spi_sclk <= 1'b0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_RWAIT;
                    end
                end
                // the byte may already have been taken during the final high half
                S_RWAIT: if (!rsp_tvalid || rsp_tready) state <= rx_left != 8'd0 ? S_RX : S_TRAIL;
`endif
                S_TRAIL: if (wait_cnt == HALF_END) begin
                    state    <= S_GAP;
                    spi_cs_n <= 1'b1;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                S_GAP: if (wait_cnt == GAP_END) state <= S_IDLE; else wait_cnt <= wait_cnt + 16'd1;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: directed self-checking bench for spi_cmd_master; read-back scenarios follow SPI_CMD_MASTER_READBACK_EN
`timescale 1ns/1ps
module tb_spi_cmd_master;
    import spi_pkg::*;
    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] cmd_code = '0;
    logic [31:0] cmd_data = '0;
    logic [7:0] cmd_rdlen = '0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [7:0] rsp_tdata;
    logic rsp_tvalid;
    logic rsp_tlast;
    logic rsp_tready = 1'b1;
    logic busy;
    logic spi_cs_n;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;
    int errors = 0;
    int checks = 0;
    int rises = 0;
    int low_cyc = 0;
    int hs = 0;
    int tx_bits = 8;
    logic tv_seen = 1'b0;
    logic [63:0] mosi_log = '0;
    logic [7:0] rx_bytes [8];
    logic rx_last [8];
    logic [7:0] resp [4] = '{8'h31, 8'h41, 8'h4C, 8'h53};

    spi_cmd_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_code  (cmd_code),
        .cmd_data  (cmd_data),
        .cmd_rdlen (cmd_rdlen),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .rsp_tdata (rsp_tdata),
        .rsp_tvalid(rsp_tvalid),
        .rsp_tlast (rsp_tlast),
        .rsp_tready(rsp_tready),
        .busy      (busy),
        .spi_cs_n  (spi_cs_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    always #5 clk = ~clk;

    // slave model: after the command bits, shift out the "1ALS" reply MSB first
    assign spi_miso = (rises >= tx_bits && rises < tx_bits + 32) ?
                      resp[(rises - tx_bits) / 8][7 - ((rises - tx_bits) % 8)] : 1'b0;

    always @(posedge spi_sclk) begin
        mosi_log = {mosi_log[62:0], spi_mosi};
        rises++;
    end

    always @(posedge clk) begin
        if (!spi_cs_n) low_cyc++;
        if (rsp_tvalid) tv_seen = 1'b1;
        if (rsp_tvalid && rsp_tready) begin
            if (hs < 8) begin
                rx_bytes[hs] = rsp_tdata;
                rx_last[hs]  = rsp_tlast;
            end
            hs++;
        end
    end

    task automatic start_cmd(input logic [7:0] c, input logic [31:0] d, input logic [7:0] n);
        int t = 0;
        while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
        rises = 0; low_cyc = 0; hs = 0; tv_seen = 1'b0; mosi_log = '0;
        tx_bits = c[LONG_BIT] ? 40 : 8;
        cmd_code = c; cmd_data = d; cmd_rdlen = n; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (t >= 1000) begin errors++; $display("FAIL accept_timeout: cmd_ready low for %0d cycles, need high within 1000", t); end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(cmd_ready && spi_cs_n) && t < 5000) begin @(negedge clk); t++; end
        checks++;
        if (t >= 5000) begin errors++; $display("FAIL idle_timeout: busy for %0d cycles, need idle within 5000", t); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b want 1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b want 0", spi_sclk); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b want 0", spi_mosi); end
        checks++; if (rsp_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", rsp_tvalid); end
        checks++; if (rsp_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", rsp_tlast); end
        checks++; if (rsp_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h want 00", rsp_tdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0 while rst high", cmd_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_long_cmd();
        start_cmd(8'hC0, 32'h12345678, 8'd0);
        wait_idle();
        checks++; if (rises != 40) begin errors++; $display("FAIL long_edges: got %0d want 40", rises); end
        checks++; if (mosi_log[39:0] !== 40'hC078563412) begin errors++; $display("FAIL long_mosi: got %h want c078563412", mosi_log[39:0]); end
        checks++; if (low_cyc != 328) begin errors++; $display("FAIL long_cs_low: got %0d want 328", low_cyc); end
        checks++; if (tv_seen !== 1'b0) begin errors++; $display("FAIL long_tvalid: got %b want 0", tv_seen); end
    endtask

`ifdef SPI_CMD_MASTER_READBACK_EN
    task automatic test_id_read();
        logic [7:0] exp [4] = '{8'h31, 8'h41, 8'h4C, 8'h53};
        rsp_tready = 1'b1;
        start_cmd(OP_QUERY_ID, 32'h0, 8'd4);
        wait_idle();
        checks++; if (mosi_log[39:32] !== 8'h02) begin errors++; $display("FAIL id_mosi: got %h want 02", mosi_log[39:32]); end
        checks++; if (mosi_log[31:0] !== 32'h0) begin errors++; $display("FAIL id_rx_mosi: got %h want 00000000", mosi_log[31:0]); end
        checks++; if (hs != 4) begin errors++; $display("FAIL id_count: got %0d want 4", hs); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_bytes[i] !== exp[i]) begin errors++; $display("FAIL id_byte%0d: got %h want %h", i, rx_bytes[i], exp[i]); end
            checks++; if (rx_last[i] !== (i == 3)) begin errors++; $display("FAIL id_last%0d: got %b want %b", i, rx_last[i], i == 3); end
        end
    endtask

    task automatic test_stall();
        int t = 0;
        int bad = 0;
        int r0;
        logic [7:0] d0;
        rsp_tready = 1'b0;
        start_cmd(OP_QUERY_ID, 32'h0, 8'd2);
        while ((!rsp_tvalid || spi_sclk) && t < 2000) begin @(negedge clk); t++; end
        checks++; if (t >= 2000) begin errors++; $display("FAIL stall_timeout: no first byte in %0d cycles", t); end
        d0 = rsp_tdata;
        r0 = rises;
        repeat (50) begin
            @(negedge clk);
            if (spi_sclk !== 1'b0 || rsp_tdata !== d0 || rsp_tvalid !== 1'b1) bad++;
        end
        checks++; if (d0 !== 8'h31) begin errors++; $display("FAIL stall_byte0: got %h want 31", d0); end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); end
        checks++; if (rises != 16 || r0 != 16) begin errors++; $display("FAIL stall_edges: got %0d/%0d want 16/16", r0, rises); end
        rsp_tready = 1'b1;
        wait_idle();
        checks++; if (hs != 2) begin errors++; $display("FAIL stall_count: got %0d want 2", hs); end
        checks++; if (rx_bytes[1] !== 8'h41) begin errors++; $display("FAIL stall_byte1: got %h want 41", rx_bytes[1]); end
        checks++; if (rx_last[0] !== 1'b0 || rx_last[1] !== 1'b1) begin errors++; $display("FAIL stall_last: got %b%b want 01", rx_last[0], rx_last[1]); end
        checks++; if (rises != 24) begin errors++; $display("FAIL stall_total_edges: got %0d want 24", rises); end
    endtask
`else
    task automatic test_no_readback();
        start_cmd(OP_QUERY_META, 32'h0, 8'd5);
        wait_idle();
        checks++; if (rises != 8) begin errors++; $display("FAIL norb_edges: got %0d want 8", rises); end
        checks++; if (mosi_log[7:0] !== 8'h04) begin errors++; $display("FAIL norb_mosi: got %h want 04", mosi_log[7:0]); end
        checks++; if (low_cyc != 72) begin errors++; $display("FAIL norb_cs_low: got %0d want 72", low_cyc); end
        checks++; if (tv_seen !== 1'b0) begin errors++; $display("FAIL norb_tvalid: got %b want 0", tv_seen); end
        checks++; if (rsp_tdata !== 8'h00) begin errors++; $display("FAIL norb_tdata: got %h want 00", rsp_tdata); end
    endtask
`endif

    task automatic test_reset_mid();
        int t = 0;
        start_cmd(8'hC0, 32'hA5A5A5A5, 8'd3);
        while (rises < 16 && t < 2000) begin @(negedge clk); t++; end
        checks++; if (t >= 2000) begin errors++; $display("FAIL mid_timeout: got %0d edges want 16", rises); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs_n: got %b want 1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk: got %b want 0", spi_sclk); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (tv_seen !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b want 0", tv_seen); end
    endtask

    task automatic test_back_to_back();
        int t = 0;
        int gap = 0;
        rises = 0; mosi_log = '0; tx_bits = 8;
        cmd_code = OP_QUERY_ID; cmd_data = 32'h0; cmd_rdlen = 8'd0; cmd_valid = 1'b1;
        while (spi_cs_n && t < 1000) begin @(negedge clk); t++; end
        cmd_code = 8'h81;
        while (!spi_cs_n && t < 2000) begin @(negedge clk); t++; end
        while (spi_cs_n && t < 3000) begin gap++; @(negedge clk); t++; end
        cmd_valid = 1'b0;
        wait_idle();
        checks++; if (t >= 3000) begin errors++; $display("FAIL b2b_timeout: got %0d cycles want under 3000", t); end
        checks++; if (gap < CS_GAP) begin errors++; $display("FAIL b2b_gap: got %0d want >= %0d", gap, CS_GAP); end
        checks++; if (rises != 48) begin errors++; $display("FAIL b2b_edges: got %0d want 48", rises); end
        checks++; if (mosi_log[47:40] !== 8'h02) begin errors++; $display("FAIL b2b_first: got %h want 02", mosi_log[47:40]); end
        checks++; if (mosi_log[39:32] !== 8'h81) begin errors++; $display("FAIL b2b_second: got %h want 81", mosi_log[39:32]); end
    endtask

    initial begin
        test_reset();
        test_long_cmd();
`ifdef SPI_CMD_MASTER_READBACK_EN
        test_id_read();
        test_stall();
`else
        test_no_readback();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
